pack_ctrl: RTL and testbench

PACK_CTRL -- requirements
Module: pack_ctrl

---
 rtl/adc_pkg.sv | 27 ++
 rtl/pack_wdt.sv | 35 +++
 rtl/pack_ctrl.sv | 148 ++++++++++++++
 tb/tb_pack_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg -- shared definitions for the packet controller.
//   State encoding (one-hot, 8-bit), the state enum built from it,
//   default DEF_LEN / TIMEOUT values, and a saturating increment helper.
package adc_pkg;

   localparam logic [7:0] ST_IDLE  = 8'h01;
   localparam logic [7:0] ST_HOLD  = 8'h02;
   localparam logic [7:0] ST_START = 8'h04;
   localparam logic [7:0] ST_DONE  = 8'h08;
   localparam logic [7:0] ST_ERR   = 8'h10;

   typedef enum logic [7:0] {
      S_IDLE  = ST_IDLE,
      S_HOLD  = ST_HOLD,
      S_START = ST_START,
      S_DONE  = ST_DONE,
      S_ERR   = ST_ERR
   } state_e;

   localparam logic [11:0] DEF_LEN_DFLT = 12'd128;
   localparam logic [15:0] TIMEOUT_DFLT = 16'd4096;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pack_wdt.sv
// pack_wdt -- watchdog counter for the START state (built only when
// PACK_CTRL_WDT_EN is defined).
//   clk, rst_n : clock, async active-low reset
//   load       : clear the count
//   run        : count one cycle
//   expire     : high in the TIMEOUT-th consecutive run cycle
`ifdef PACK_CTRL_WDT_EN
module pack_wdt import adc_pkg::*; #(
   parameter logic [15:0] TIMEOUT = TIMEOUT_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expire
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)     cnt_d = '0;
      else if (run) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Count starts at 0 in the first run cycle, so TIMEOUT-1 marks the last one.
   assign expire = run & (cnt_q == TIMEOUT - 16'd1);

endmodule
`endif

// File: rtl/pack_ctrl.sv
// pack_ctrl -- sequences one packet per trigger towards a packet writer.
//   Inputs : clk, rst_n (async low), en, trig, len_cfg[11:0], fifo_full,
//            clr, wr_fd (writer done level)
//   Outputs: wr_fs (writer start), wr_data_len[11:0], wr_part[15:0],
//            busy, err (sticky watchdog), ovf_cnt[7:0] (dropped triggers)
//   Macro PACK_CTRL_WDT_EN: builds the START watchdog and the ERR path.
//   PART_INIT sets the reset value of wr_part (0 in normal use).
module pack_ctrl import adc_pkg::*; #(
   parameter logic [11:0] DEF_LEN   = DEF_LEN_DFLT,
   parameter logic [15:0] TIMEOUT   = TIMEOUT_DFLT,
   parameter logic [15:0] PART_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        trig,
   input  logic [11:0] len_cfg,
   input  logic        fifo_full,
   input  logic        clr,
   output logic        wr_fs,
   input  logic        wr_fd,
   output logic [11:0] wr_data_len,
   output logic [15:0] wr_part,
   output logic        busy,
   output logic        err,
   output logic [7:0]  ovf_cnt
);

   state_e      state_q, state_d;
   logic        wr_fs_q, wr_fs_d;
   logic        pend_q, pend_d;
   logic [11:0] len_q, len_d;
   logic [15:0] part_q, part_d;
   logic [7:0]  ovf_q, ovf_d;
   logic        go, consumed, wdt_exp;

`ifdef PACK_CTRL_WDT_EN
   logic err_q, err_d;

   pack_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state_q != S_START),
      .run    (state_q == S_START),
      .expire (wdt_exp)
   );

   always_comb begin
      err_d = err_q;
      if (wdt_exp)  err_d = 1'b1;
      else if (clr) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign wdt_exp = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      len_d    = len_q;
      part_d   = part_q;
      ovf_d    = ovf_q;
      consumed = 1'b0;
      go       = (trig | pend_q) & en;

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               consumed = trig;
               if (fifo_full) begin
                  state_d = S_HOLD;
                  // The waiting request lives in pend until START, so an
                  // en drop in HOLD does not lose it.
                  pend_d  = 1'b1;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_HOLD: begin
            if (!en)            state_d = S_IDLE;
            else if (!fifo_full) state_d = S_START;
         end
         S_START: begin
            if (wr_fd)        state_d = S_DONE;
            else if (wdt_exp) state_d = S_ERR;
         end
         S_DONE: begin
            if (!wr_fd) begin
               state_d = S_IDLE;
               part_d  = part_q + 16'd1;
            end
         end
         S_ERR: begin
            if (clr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Any trigger not taken by a start decision queues once, then drops.
      if (trig && !consumed) begin
         if (pend_q) ovf_d  = sat_inc8(ovf_q);
         else        pend_d = 1'b1;
      end

      if (state_d == S_START && state_q != S_START) begin
         len_d  = (len_cfg == 12'd0) ? DEF_LEN : len_cfg;
         pend_d = 1'b0;
      end

      if (clr) ovf_d = '0;

      wr_fs_d = (state_d == S_START);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wr_fs_q <= 1'b0;
         pend_q  <= 1'b0;
         len_q   <= DEF_LEN;
         part_q  <= PART_INIT;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_fs_q <= wr_fs_d;
         pend_q  <= pend_d;
         len_q   <= len_d;
         part_q  <= part_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wr_fs       = wr_fs_q;
   assign wr_data_len = len_q;
   assign wr_part     = part_q;
   assign busy        = (state_q != S_IDLE);
   assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_pack_ctrl.sv
// tb_pack_ctrl -- directed checks for pack_ctrl. A second instance with
// wr_part starting at 16'hFFFF shares all inputs and shows the wrap.
// Watchdog steps depend on PACK_CTRL_WDT_EN.
module tb_pack_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, en, trig, fifo_full, clr, wr_fd;
   logic [11:0] len_cfg;
   logic        wr_fs, busy, err;
   logic [11:0] wr_data_len;
   logic [15:0] wr_part;
   logic [7:0]  ovf_cnt;
   logic        wr_fs2, busy2, err2;
   logic [11:0] wr_data_len2;
   logic [15:0] wr_part2;
   logic [7:0]  ovf_cnt2;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pack_ctrl #(.TIMEOUT(16'd16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .len_cfg(len_cfg),
      .fifo_full(fifo_full), .clr(clr), .wr_fs(wr_fs), .wr_fd(wr_fd),
      .wr_data_len(wr_data_len), .wr_part(wr_part), .busy(busy),
      .err(err), .ovf_cnt(ovf_cnt)
   );

   pack_ctrl #(.TIMEOUT(16'd16), .PART_INIT(16'hFFFF)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .len_cfg(len_cfg),
      .fifo_full(fifo_full), .clr(clr), .wr_fs(wr_fs2), .wr_fd(wr_fd),
      .wr_data_len(wr_data_len2), .wr_part(wr_part2), .busy(busy2),
      .err(err2), .ovf_cnt(ovf_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; trig = 1'b0; fifo_full = 1'b0;
      clr = 1'b0; wr_fd = 1'b0; len_cfg = 12'd0;
      tick(); tick();
      chk("rst_wr_fs",  wr_fs,       0);
      chk("rst_len",    wr_data_len, 128);
      chk("rst_part",   wr_part,     0);
      chk("rst_part2",  wr_part2,    16'hFFFF);
      chk("rst_busy",   busy,        0);
      chk("rst_err",    err,         0);
      chk("rst_ovf",    ovf_cnt,     0);
      rst_n = 1'b1;
      tick();

      // single packet, default length, len change during START ignored
      en = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
      chk("p1_wr_fs",   wr_fs,       1);
      chk("p1_busy",    busy,        1);
      chk("p1_len_def", wr_data_len, 128);
      len_cfg = 12'd5; tick();
      chk("p1_len_hold", wr_data_len, 128);
      wr_fd = 1'b1; tick();
      chk("p1_done_fs", wr_fs,       0);
      chk("p1_done_part", wr_part,   0);
      wr_fd = 1'b0; tick();
      chk("p1_part",    wr_part,     1);
      chk("p1_idle",    busy,        0);
      chk("wrap_part2", wr_part2,    16'h0000);

      // explicit length
      trig = 1'b1; tick(); trig = 1'b0;
      chk("p2_len5",    wr_data_len, 5);
      wr_fd = 1'b1; tick(); wr_fd = 1'b0; tick();
      chk("p2_part",    wr_part,     2);

      // backpressure: trig at cycle 0, fifo_full falls at cycle 20
      fifo_full = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
      chk("bp_busy",    busy,        1);
      chk("bp_fs0",     wr_fs,       0);
      repeat (19) tick();
      chk("bp_fs_c20",  wr_fs,       0);
      fifo_full = 1'b0; tick();
      chk("bp_fs_c21",  wr_fs,       1);
      wr_fd = 1'b1; tick(); wr_fd = 1'b0; tick();
      chk("bp_part",    wr_part,     3);

      // overrun: three trigs during one packet
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (3) begin
         trig = 1'b1; tick(); trig = 1'b0; tick();
      end
      chk("ov_cnt2",    ovf_cnt,     2);
      chk("ov_fs",      wr_fs,       1);
      wr_fd = 1'b1; tick(); wr_fd = 1'b0; tick();
      chk("ov_part",    wr_part,     4);
      chk("ov_idle",    busy,        0);
      tick();
      chk("ov_auto_fs", wr_fs,       1);
      chk("ov_auto_busy", busy,      1);
      // second packet: queue one, then clr wins over a coincident drop
      trig = 1'b1; tick();
      chk("ov_queue",   ovf_cnt,     2);
      clr = 1'b1; tick(); clr = 1'b0; trig = 1'b0;
      chk("clr_wins",   ovf_cnt,     0);
      wr_fd = 1'b1; tick();
      trig = 1'b1; repeat (300) tick(); trig = 1'b0;
      chk("ovf_sat",    ovf_cnt,     8'hFF);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("ovf_clr",    ovf_cnt,     0);
      wr_fd = 1'b0; tick();
      chk("ov2_part",   wr_part,     5);
      tick();
      chk("ov3_fs",     wr_fs,       1);
      wr_fd = 1'b1; tick(); wr_fd = 1'b0; tick(); tick();
      chk("ov3_idle",   busy,        0);
      chk("ov3_part",   wr_part,     6);
      chk("ov3_part2",  wr_part2,    5);

      // en=0 while in HOLD returns to IDLE
      fifo_full = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
      chk("hold_busy",  busy,        1);
      en = 1'b0; tick();
      chk("hold_en0",   busy,        0);
      fifo_full = 1'b0;
      #2 rst_n = 1'b0; #2 rst_n = 1'b1;
      tick();

      // async reset mid-packet
      en = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
      chk("ar_fs1",     wr_fs,       1);
      chk("ar_len",     wr_data_len, 5);
      #2 rst_n = 1'b0; #1;
      chk("ar_fs0",     wr_fs,       0);
      chk("ar_busy",    busy,        0);
      chk("ar_part",    wr_part,     0);
      chk("ar_part2",   wr_part2,    16'hFFFF);
      chk("ar_len_def", wr_data_len, 128);
      #2 rst_n = 1'b1;
      tick();

`ifdef PACK_CTRL_WDT_EN
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (15) tick();
      chk("wdt_fs_15",  wr_fs,       1);
      chk("wdt_err_15", err,         0);
      tick();
      chk("wdt_err",    err,         1);
      chk("wdt_fs0",    wr_fs,       0);
      chk("wdt_busy",   busy,        1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("wdt_clr_err", err,        0);
      chk("wdt_clr_idle", busy,      0);
      chk("wdt_part",   wr_part,     0);
`else
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (40) tick();
      chk("nowdt_fs",   wr_fs,       1);
      chk("nowdt_err",  err,         0);
      wr_fd = 1'b1; tick(); wr_fd = 1'b0; tick();
      chk("nowdt_part", wr_part,     1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
